// File: rtl/cpu_pkg.sv
// Shared definitions for the MEM-stage data-memory responder.
package cpu_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned DM_ADDR_LSB = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } dmem_req_t;

  // Misaligned byte address or word index past the end of the array.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int unsigned depth);
    return (addr[DM_ADDR_LSB-1:0] != '0) ||
           (WORD_W'(addr[WORD_W-1:DM_ADDR_LSB]) >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: synchronous write, registered synchronous read.
module dmem_array
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned IDX_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] DM [DEPTH];

  // Contents survive reset so a preloaded image is kept.
  always_ff @(posedge clk) begin
    if (en && we) begin
      DM[idx] <= wdata;
    end
  end

  // Read data is zero on every cycle that does not carry a good load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else begin
      rdata <= (en && !we) ? DM[idx] : '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: fixed-latency word load/store with pipeline stall.
module dmem_responder
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stall
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dmem_req_t        lat_q, lat_d, op;
  logic             accept, fire, op_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (req_valid && req_ready) begin
          accept  = 1'b1;
          lat_d   = '{we: req_we, addr: req_addr, wdata: req_wdata};
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The access commits on the edge entering RESP; a LATENCY=1 accept uses the live request.
  always_comb begin
    op     = accept ? lat_d : lat_q;
    fire   = (state_d == RESP);
    op_err = addr_err(op.addr, DEPTH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready <= 1'b1;
      stall     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      req_ready <= (state_d != WAIT);
      stall     <= (state_d == WAIT);
      rsp_valid <= fire;
      rsp_err   <= fire && op_err;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) MEM (
    .clk   (clk),
    .rst   (rst),
    .en    (fire && !op_err),
    .we    (op.we),
    .idx   (IDX_W'(op.addr[WORD_W-1:DM_ADDR_LSB])),
    .wdata (op.wdata),
    .rdata (rsp_rdata)
  );

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the MEM stage of the 5-stage MIPS pipeline.
- The MEM stage is the initiator: it issues word load/store requests over a valid/ready handshake.
- This block accepts each request, models a fixed access latency and returns a one-cycle response.
- It drives a stall line so the pipeline freezes while an access is outstanding.

Parameters:
- DEPTH, 128, number of 32-bit words in the storage array.
- LATENCY, 2, cycles from the accept edge to the rsp_valid cycle; legal range 1..15.
- CNT_W, 4, width of the latency counter; must hold LATENCY-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- req_valid  input  1  MEM stage presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store word, 0 = load word.
- req_addr  input  32  byte address; word index = req_addr[31:2].
- req_wdata  input  32  store data.
- rsp_valid  output  1  response valid; one-cycle pulse.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  misaligned or out-of-range access; qualified by rsp_valid.
- stall  output  1  pipeline freeze request.

Behaviour:
- Storage: array DM[0:DEPTH-1] of 32-bit words.
  - Not cleared by reset; benches preload it hierarchically as cpu.MEM.DM.
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, stall=0.
  - All latched request fields cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1, stall=0.
  - On req_valid&&req_ready: latch we/addr/wdata, counter=LATENCY-1.
  - Next state is RESP if LATENCY==1, else WAIT.
- WAIT:
  - req_ready=0, stall=1.
  - Counter decrements each cycle; when counter==1, next state is RESP.
- RESP (one cycle):
  - rsp_valid=1, stall=0, req_ready=1.
  - Back-to-back accept is allowed: a new request in RESP is latched exactly as in IDLE, with the same next-state rule.
  - With no new request, next state is IDLE.
- Latency: rsp_valid is high in exactly cycle N+LATENCY, where N is the accept cycle. Throughput is one access per LATENCY cycles.
- Memory timing:
  - The store commits to DM on the clock edge that enters RESP.
  - The load reads DM on the same edge; rsp_rdata/rsp_err are registered outputs of that edge.
  - A load accepted in RESP following a store to the same word returns the new data.
- Error conditions: req_addr[1:0]!=0, or word index >= DEPTH.
  - rsp_err=1, rsp_rdata=0, no write to DM.
  - Latency is unchanged.
- Outside RESP: rsp_rdata and rsp_err hold 0.
- req_valid=0: no state change in IDLE.
- req_* fields are ignored when req_ready=0; no capture.
- Reset mid-WAIT: the pending access is discarded; no write commits and no response is issued.
- Counter: never underflows; LATENCY==1 never enters WAIT.

Decomposition:
- Shared package (cpu_pkg):
  - state encoding IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - word width constant 32;
  - error-check helper constant DM_ADDR_LSB=2.
- One natural sub-module: dmem_array (DEPTH x 32 synchronous-write/synchronous-read storage holding DM).
- The FSM/counter stays in dmem_responder.

Test Plan:
- Reset/preload: hold rst=0 for 12 ns with DM[0]=9, DM[1]=3 preloaded -> all outputs at reset values; DM[0]=9 and DM[1]=3 intact after release.
- Load latency (LATENCY=2): load addr 0x4 accepted at cycle N -> stall=1 in N+1, rsp_valid=1 with rsp_rdata=3 and rsp_err=0 in N+2, stall=0 in N+2.
- Store then load back-to-back: store 0x8 wdata 0x0000002A; issue load 0x8 in the RESP cycle -> second response rsp_rdata=0x2A; DM[2]=0x2A.
- Errors: load 0x3 and store 0x200 (word 128) -> each gets rsp_err=1, rsp_rdata=0; DM unchanged; latency still 2.
- LATENCY=1 build: continuous loads to 0x0, 0x4 -> rsp_valid every cycle with data 9, 3; stall never asserts.
- Reset mid-WAIT: store 0xC wdata 0x55, drop rst in the WAIT cycle -> no rsp_valid; DM[3] stays 0; req_ready=1 after release.
